// File: rtl/piano_pkg.sv
// Shared definitions for the piano keyboard logic.
//   NUM_KEYS / KEY_IDX_W : eight keys C4..C5, encoded in 3 bits.
//   NOTE_LIMIT           : divider terminal counts, one per key.
//   voice_state_e        : per-voice allocation state.
package piano_pkg;

  localparam int NUM_KEYS     = 8;
  localparam int KEY_IDX_W    = 3;
  // Narrowest period width that still holds every NOTE_LIMIT entry.
  localparam int NOTE_LIMIT_W = 17;

  localparam int unsigned NOTE_LIMIT [NUM_KEYS] = '{
    95566, 85121, 75850, 71592, 63776, 56818, 50618, 47774
  };

  typedef logic [KEY_IDX_W-1:0] key_idx_t;

  typedef enum logic {
    FREE   = 1'b0,
    ACTIVE = 1'b1
  } voice_state_e;

endpackage

// File: rtl/voice_allocator_if.sv
// Bundle between the key conditioners, the voice allocator and the voice
// dividers.
//   key_down     : debounced key levels, bit k = note k.
//   voice_en     : voice v is sounding.
//   voice_period : terminal count, slice v = [v*PERIOD_W +: PERIOD_W].
//   voice_key    : owning key index, slice v = [v*3 +: 3].
//   voice_load   : 1-cycle pulse, voice v restarts its divider from 0.
//   dropped      : 1-cycle pulse, a press was denied for lack of a voice.
//   busy         : all voices are allocated.
// master = allocator side, slave = key/divider side.
interface voice_allocator_if #(
  parameter int NUM_VOICES = 4,
  parameter int PERIOD_W   = 17
);
  import piano_pkg::*;

  logic [NUM_KEYS-1:0]            key_down;
  logic [NUM_VOICES-1:0]          voice_en;
  logic [NUM_VOICES*PERIOD_W-1:0] voice_period;
  logic [NUM_VOICES*KEY_IDX_W-1:0] voice_key;
  logic [NUM_VOICES-1:0]          voice_load;
  logic                           dropped;
  logic                           busy;

  modport master (
    input  key_down,
    output voice_en, voice_period, voice_key, voice_load, dropped, busy
  );

  modport slave (
    output key_down,
    input  voice_en, voice_period, voice_key, voice_load, dropped, busy
  );

endinterface

// File: rtl/note_period_rom.sv
// Combinational key index -> divider terminal count lookup.
//   key_idx : note index 0 (C4) .. 7 (C5).
//   period  : NOTE_LIMIT[key_idx], zero-extended/truncated to PERIOD_W.
module note_period_rom
  import piano_pkg::*;
#(
  parameter int PERIOD_W = 17
) (
  input  key_idx_t            key_idx,
  output logic [PERIOD_W-1:0] period
);

  always_comb begin
    period = PERIOD_W'(NOTE_LIMIT[key_idx]);
  end

endmodule

// File: rtl/voice_allocator.sv
// Shares NUM_VOICES tone-divider voices among the eight piano keys.
// One key is evaluated per cycle by a free-running round-robin scan pointer;
// a newly pressed key takes the lowest-index free voice, a released key
// returns its voice. All outputs are registered.
//   clk   : system clock.
//   reset : synchronous, active-high.
//   bus   : voice_allocator_if master modport (key_down in, voice outputs).
module voice_allocator
  import piano_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PERIOD_W   = 17
) (
  input  logic                clk,
  input  logic                reset,
  voice_allocator_if.master   bus
);

  if (PERIOD_W < NOTE_LIMIT_W) begin : g_bad_period_w
    $error("voice_allocator: PERIOD_W must be at least 17");
  end
  if (NUM_VOICES < 1 || NUM_VOICES > 8) begin : g_bad_num_voices
    $error("voice_allocator: NUM_VOICES must be 1..8");
  end

  // Scan and allocation state.
  key_idx_t     scan_ptr;
  voice_state_e voice_state [NUM_VOICES];
  logic [NUM_KEYS-1:0] assigned;
  logic [NUM_KEYS-1:0] denied;
  key_idx_t     owner_voice [NUM_KEYS];

  // Free-voice priority encoder results.
  logic [NUM_VOICES-1:0] free_vec;
  key_idx_t              free_idx;
  logic                  any_free;
  logic                  last_free;

  logic [PERIOD_W-1:0]   rom_period;
  logic                  cur_down;

  note_period_rom #(.PERIOD_W(PERIOD_W)) u_rom (
    .key_idx (scan_ptr),
    .period  (rom_period)
  );

  assign cur_down = bus.key_down[scan_ptr];

  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    free_vec = '0;
    free_idx = '0;
    any_free = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      free_vec[v] = (voice_state[v] == FREE);
    end
    // Walk downward so the lowest-index free voice wins.
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (free_vec[v]) begin
        free_idx = key_idx_t'(v);
        any_free = 1'b1;
      end
    end
    // Exactly one voice free: granting it makes the pool full.
    last_free = any_free && ((free_vec & (free_vec - NUM_VOICES'(1))) == '0);
  end

  always_comb begin
    bus.voice_en = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      bus.voice_en[v] = (voice_state[v] == ACTIVE);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_ptr         <= '0;
      assigned         <= '0;
      denied           <= '0;
      bus.voice_period <= '0;
      bus.voice_key    <= '0;
      bus.voice_load   <= '0;
      bus.dropped      <= 1'b0;
      bus.busy         <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        voice_state[v] <= FREE;
      end
      // NOTE: the small per-key flag arrays are real control state and must
      // be reset; a stale owner entry would free the wrong voice later.
      for (int k = 0; k < NUM_KEYS; k++) begin
        owner_voice[k] <= '0;
      end
    end else begin
      scan_ptr       <= scan_ptr + key_idx_t'(1);
      bus.voice_load <= '0;
      bus.dropped    <= 1'b0;

      if (cur_down && !assigned[scan_ptr]) begin
        if (any_free) begin
          // Grant: lowest free voice starts this note from a fresh divider.
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (key_idx_t'(v) == free_idx) begin
              voice_state[v]                          <= ACTIVE;
              bus.voice_period[v*PERIOD_W +: PERIOD_W] <= rom_period;
              bus.voice_key[v*KEY_IDX_W +: KEY_IDX_W]  <= scan_ptr;
              bus.voice_load[v]                       <= 1'b1;
            end
          end
          assigned[scan_ptr]    <= 1'b1;
          denied[scan_ptr]      <= 1'b0;
          owner_voice[scan_ptr] <= free_idx;
          bus.busy              <= last_free;
        end else if (!denied[scan_ptr]) begin
          // Report a denial once per press; later passes retry silently.
          bus.dropped      <= 1'b1;
          denied[scan_ptr] <= 1'b1;
        end
      end else if (!cur_down && assigned[scan_ptr]) begin
        // Release: period and key outputs keep their last value.
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (key_idx_t'(v) == owner_voice[scan_ptr]) begin
            voice_state[v] <= FREE;
          end
        end
        assigned[scan_ptr] <= 1'b0;
        bus.busy           <= 1'b0;
      end else if (!cur_down) begin
        denied[scan_ptr] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int PW = 17;

  typedef struct packed {
    logic        is_drop;
    logic [2:0]  voice;
    logic [2:0]  key;
    logic [16:0] period;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] tb_p = '0;

  int total = 0;
  int bad   = 0;
  ev_t exp_q [$];

  always #5 clk = ~clk;

  voice_allocator_if #(.NUM_VOICES(NV), .PERIOD_W(PW)) bus ();

  voice_allocator #(.NUM_VOICES(NV), .PERIOD_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Independent model of the scan position (key evaluated at the next edge).
  always @(posedge clk) tb_p <= reset ? 3'd0 : tb_p + 3'd1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic ev_t load_ev(input int v, input int k, input int per);
    ev_t e;
    e.is_drop = 1'b0;
    e.voice   = 3'(v);
    e.key     = 3'(k);
    e.period  = 17'(per);
    return e;
  endfunction

  function automatic ev_t drop_ev();
    ev_t e;
    e = '0;
    e.is_drop = 1'b1;
    return e;
  endfunction

  task automatic compare_event(input ev_t got);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected event", 64'(got), 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("event", 64'(got), 64'(e));
    end
  endtask

  // Monitor: every load or dropped pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      for (int v = 0; v < NV; v++) begin
        if (bus.voice_load[v]) begin
          compare_event(load_ev(v, int'(bus.voice_key[v*3 +: 3]),
                                int'(bus.voice_period[v*PW +: PW])));
        end
      end
      if (bus.dropped) compare_event(drop_ev());
    end
  end

  task automatic wait_p(input logic [2:0] k);
    for (int i = 0; i < 16 && tb_p != k; i++) @(negedge clk);
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_en(input logic [NV-1:0] want, input int budget);
    for (int i = 0; i < budget && bus.voice_en !== want; i++) @(negedge clk);
  endtask

  initial begin
    bus.key_down = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Idle after reset.
    repeat (20) @(negedge clk);
    check("idle voice_en", 64'(bus.voice_en), 64'd0);
    check("idle voice_load", 64'(bus.voice_load), 64'd0);
    check("idle dropped", 64'(bus.dropped), 64'd0);
    check("idle busy", 64'(bus.busy), 64'd0);
    check("idle periods", 64'(bus.voice_period), 64'd0);
    check("idle keys", 64'(bus.voice_key), 64'd0);

    // Single key 0.
    exp_q.push_back(load_ev(0, 0, 95566));
    bus.key_down = 8'h01;
    drain("key0 grant", 10);
    check("key0 voice_en", 64'(bus.voice_en), 64'h1);
    check("key0 period", 64'(bus.voice_period[0 +: PW]), 64'd95566);
    check("key0 key", 64'(bus.voice_key[0 +: 3]), 64'd0);
    check("key0 others period", 64'(bus.voice_period[PW +: 3*PW]), 64'd0);
    repeat (16) @(negedge clk);

    // Keys 0..4, pressed just before key 1 is scanned.
    wait_p(3'd1);
    exp_q.push_back(load_ev(1, 1, 85121));
    exp_q.push_back(load_ev(2, 2, 75850));
    exp_q.push_back(load_ev(3, 3, 71592));
    exp_q.push_back(drop_ev());
    bus.key_down = 8'h1F;
    drain("fill grants", 12);
    repeat (24) @(negedge clk);
    check("fill voice_en", 64'(bus.voice_en), 64'hF);
    check("fill busy", 64'(bus.busy), 64'd1);
    check("fill keys", 64'(bus.voice_key), 64'({3'd3, 3'd2, 3'd1, 3'd0}));

    // Release key 1: waiting key 4 takes voice 1.
    exp_q.push_back(load_ev(1, 4, 63776));
    bus.key_down = 8'h1D;
    drain("steal grant", 16);
    #1;
    check("steal busy", 64'(bus.busy), 64'd1);
    check("steal key", 64'(bus.voice_key[3 +: 3]), 64'd4);
    check("steal period", 64'(bus.voice_period[PW +: PW]), 64'd63776);

    // Release key 0: voice 0 freed, period held.
    bus.key_down = 8'h1C;
    wait_en(4'b1110, 10);
    check("rel0 voice_en", 64'(bus.voice_en), 64'hE);
    check("rel0 period held", 64'(bus.voice_period[0 +: PW]), 64'd95566);
    check("rel0 busy", 64'(bus.busy), 64'd0);

    // Re-press key 0 to fill the pool, then reset.
    exp_q.push_back(load_ev(0, 0, 95566));
    bus.key_down = 8'h1D;
    drain("repress grant", 10);
    #1;
    check("repress busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst voice_en", 64'(bus.voice_en), 64'd0);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst periods", 64'(bus.voice_period), 64'd0);
    check("rst keys", 64'(bus.voice_key), 64'd0);
    check("rst load", 64'(bus.voice_load), 64'd0);
    exp_q.push_back(load_ev(0, 0, 95566));
    exp_q.push_back(load_ev(1, 2, 75850));
    exp_q.push_back(load_ev(2, 3, 71592));
    exp_q.push_back(load_ev(3, 4, 63776));
    reset = 1'b0;
    drain("post-reset grants", 10);
    #1;
    check("post-reset keys", 64'(bus.voice_key), 64'({3'd4, 3'd3, 3'd2, 3'd0}));
    check("post-reset busy", 64'(bus.busy), 64'd1);

    // Free voice 3, then a key-5 pulse hidden between two visits.
    bus.key_down = 8'h0D;
    wait_en(4'b0111, 10);
    check("rel4 voice_en", 64'(bus.voice_en), 64'h7);
    wait_p(3'd6);
    bus.key_down = 8'h2D;
    repeat (2) @(negedge clk);
    bus.key_down = 8'h0D;
    repeat (16) @(negedge clk);
    check("pulse voice_en", 64'(bus.voice_en), 64'h7);
    check("pulse busy", 64'(bus.busy), 64'd0);
    check("pulse no events", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
